instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for mem_ack.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port pc_next, input, 32: next-PC value from the next-PC adder (PC+4, PC+imm or RS+imm).
REQ-006 SHALL have port pc_load, input, 1: control-unit pulse that commits pc_next after the current instruction executes.
REQ-007 SHALL have port mem_req, output, 1: instruction memory read request.
REQ-008 SHALL have port mem_addr, output, 32: instruction memory word address (equals PC).
REQ-009 SHALL have port mem_ack, input, 1: memory data-valid strobe.
REQ-010 SHALL have port mem_rdata, input, 32: memory read data.
REQ-011 SHALL have port instr, output, 32: registered instruction word.
REQ-012 SHALL have port instr_valid, output, 1: instr and addr_instruction are valid.
REQ-013 SHALL have port instr_ready, input, 1: decoder accepts the instruction.
REQ-014 SHALL have port addr_instruction, output, 32: PC of instr, fed back to the next-PC adder.
REQ-015 SHALL have port fault, output, 2: sticky fault code (00 none, 01 misaligned, 10 timeout).

Function
REQ-016 SHALL implement states FETCH, HOLD, WAIT_PC, FAULT.
REQ-017 In FETCH, SHALL drive mem_req=1 and mem_addr=PC; mem_addr SHALL remain stable until mem_ack.
REQ-018 On mem_ack in FETCH, SHALL register mem_rdata into instr, set instr_valid=1 on the next cycle, and go to HOLD (1-cycle ack-to-valid latency).
REQ-019 SHALL drive mem_req=0 in every state other than FETCH, and during the cycle after mem_ack.
REQ-020 In HOLD, instr, addr_instruction and instr_valid SHALL remain stable until instr_ready=1; the handshake completes on instr_valid & instr_ready, after which instr_valid=0 and the state is WAIT_PC.
REQ-021 In WAIT_PC, on pc_load=1, SHALL load PC<=pc_next and enter FETCH on the next cycle.
REQ-022 pc_load asserted in FETCH or HOLD SHALL be ignored, with no PC change.
REQ-023 pc_load with pc_next[1:0]!=2'b00 SHALL leave PC unchanged, set fault=01, and enter FAULT.
REQ-024 SHALL count wait cycles in FETCH; reaching TIMEOUT without mem_ack SHALL set fault=10 and enter FAULT.
REQ-025 The wait counter SHALL clear on entry to FETCH and on mem_ack.
REQ-026 FAULT SHALL be absorbing until rst: mem_req=0, instr_valid=0, fault held.
REQ-027 addr_instruction SHALL equal the PC captured with the instruction and SHALL NOT change while instr_valid=1.
REQ-028 PC arithmetic SHALL be 32-bit; pc_next 32'hFFFF_FFFC SHALL be accepted with no wrap check.

Reset
REQ-029 On rst=1 at a clock edge, SHALL set PC=RESET_PC, state=FETCH, instr=0, instr_valid=0, fault=00 and counter=0; mem_req SHALL be 0 during reset and 1 in the first cycle after it.
REQ-030 rst asserted mid-transaction SHALL discard any pending request, and a mem_ack in the reset cycle SHALL be ignored.
REQ-031 rst SHALL take priority over every other input.

Structure
REQ-032 State encodings and the fault codes (NONE, MISALIGNED, TIMEOUT) SHALL live in a shared processor package.
REQ-033 The wait counter SHALL be the sub-module fetch_timeout_counter, with clear, enable and expired ports.
REQ-034 SHALL contain no combinational path from mem_rdata to instr.

Verification
REQ-035 Reset with RESET_PC=0, then mem_ack=1 with mem_rdata=32'h00500093 two cycles later -> mem_addr=0, instr=32'h00500093, instr_valid=1, addr_instruction=0.
REQ-036 Hold instr_ready=0 for 5 cycles, then pulse it, then pc_load with pc_next=32'h4 -> instr stable for 5 cycles, then mem_req=1 with mem_addr=32'h4.
REQ-037 pc_load=1 with pc_next=32'h100 during FETCH, then again in WAIT_PC -> first pulse ignored; next fetch at 32'h100 only after the second.
REQ-038 pc_load with pc_next=32'h102 -> fault=01, mem_req=0, PC unchanged, FAULT held until rst.
REQ-039 mem_ack withheld for 16 cycles -> fault=10, mem_req=0 from the next cycle.
REQ-040 rst during a FETCH wait, with mem_ack coinciding with rst -> instr_valid=0, PC=RESET_PC, new fetch of RESET_PC after rst deasserts.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared processor types for the instruction fetch stage.
// Holds the FSM state encodings, fault codes and the fetched-word payload.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_HOLD    = 2'b01,
        ST_WAIT_PC = 2'b10,
        ST_FAULT   = 2'b11
    } fetch_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_TIMEOUT    = 2'b10
    } fault_e;

    // Instruction word paired with the PC it was fetched from
    typedef struct packed {
        word_t instr;
        word_t addr;
    } fetch_pkt_t;

    function automatic logic is_word_aligned(input word_t addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: next-PC control, instruction memory port and decoder handshake.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    word_t  pc_next;
    logic   pc_load;
    logic   mem_req;
    word_t  mem_addr;
    logic   mem_ack;
    word_t  mem_rdata;
    word_t  instr;
    logic   instr_valid;
    logic   instr_ready;
    word_t  addr_instruction;
    fault_e fault;

    modport master (
        input  pc_next, pc_load, mem_ack, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr, instr_valid, addr_instruction, fault
    );

    modport slave (
        output pc_next, pc_load, mem_ack, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr, instr_valid, addr_instruction, fault
    );

endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting for the memory acknowledge.
// expired_o flags that the current wait cycle is the TIMEOUT-th one.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

    // Saturates at the last wait cycle; the FSM leaves FETCH at that point
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory and hands
// registered instructions to the decoder, trapping on misalignment or timeout.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter word_t       RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic clk,
    input  logic rst,
    instr_fetch_if.master bus
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    fetch_pkt_t   pkt_q, pkt_d;
    logic         valid_q, valid_d;
    logic         mem_req_q, mem_req_d;
    fault_e       fault_q, fault_d;

    logic fetch_ack;
    logic wait_en;
    logic cnt_clear;
    logic cnt_expired;

    // An ack only counts while a request is actually on the bus
    assign fetch_ack = (state_q == ST_FETCH) && mem_req_q && bus.mem_ack;
    assign wait_en   = (state_q == ST_FETCH) && mem_req_q && !bus.mem_ack;
    assign cnt_clear = fetch_ack || ((state_q != ST_FETCH) && (state_d == ST_FETCH));

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cnt_clear),
        .enable_i  (wait_en),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pkt_d   = pkt_q;
        valid_d = valid_q;
        fault_d = fault_q;

        case (state_q)
            ST_FETCH: begin
                if (fetch_ack) begin
                    pkt_d.instr = bus.mem_rdata;
                    pkt_d.addr  = pc_q;
                    valid_d     = 1'b1;
                    state_d     = ST_HOLD;
                end else if (wait_en && cnt_expired) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = ST_FAULT;
                end
            end
            ST_HOLD: begin
                if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT_PC;
                end
            end
            ST_WAIT_PC: begin
                if (bus.pc_load) begin
                    if (is_word_aligned(bus.pc_next)) begin
                        pc_d    = bus.pc_next;
                        state_d = ST_FETCH;
                    end else begin
                        fault_d = FAULT_MISALIGNED;
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                valid_d = 1'b0;
            end
        endcase

        mem_req_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            pkt_q     <= '{instr: '0, addr: RESET_PC};
            valid_q   <= 1'b0;
            mem_req_q <= 1'b0;
            fault_q   <= FAULT_NONE;
        end else begin
            pc_q      <= pc_d;
            pkt_q     <= pkt_d;
            valid_q   <= valid_d;
            mem_req_q <= mem_req_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.mem_req          = mem_req_q;
    assign bus.mem_addr         = pc_q;
    assign bus.instr            = pkt_q.instr;
    assign bus.addr_instruction = pkt_q.addr;
    assign bus.instr_valid      = valid_q;
    assign bus.fault            = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: transaction-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam word_t       RST_PC  = 32'h0000_0000;
    localparam int unsigned TMO     = 16;

    logic clk;
    logic rst;
    instr_fetch_if bus();

    instr_fetch #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks what the fetch unit is doing at transaction level
    logic        m_init = 1'b0;
    logic        m_req, m_valid, m_await_pc, m_dead;
    logic [31:0] m_pc, m_instr, m_addr;
    logic [1:0]  m_fault;
    int          m_waits;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_await_pc = 1'b0;
            m_dead = 1'b0; m_pc = RST_PC; m_instr = '0; m_addr = RST_PC;
            m_fault = 2'b00; m_waits = 0;
        end else if (m_init) begin
            if (m_dead) begin
                m_req = 1'b0; m_valid = 1'b0;
            end else if (m_req) begin
                if (bus.mem_ack) begin
                    m_instr = bus.mem_rdata; m_addr = m_pc; m_valid = 1'b1;
                    m_req = 1'b0; m_waits = 0;
                end else begin
                    m_waits++;
                    if (m_waits == TMO) begin
                        m_fault = 2'b10; m_dead = 1'b1; m_req = 1'b0;
                    end
                end
            end else if (m_valid) begin
                if (bus.instr_ready) begin
                    m_valid = 1'b0; m_await_pc = 1'b1;
                end
            end else if (m_await_pc) begin
                if (bus.pc_load) begin
                    if (bus.pc_next[1:0] != 2'b00) begin
                        m_fault = 2'b01; m_dead = 1'b1;
                    end else begin
                        m_pc = bus.pc_next; m_req = 1'b1; m_await_pc = 1'b0; m_waits = 0;
                    end
                end
            end else begin
                m_req = 1'b1; m_waits = 0;
            end
        end
    end

    // Cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (m_init) begin
            chk("m_req",   32'(bus.mem_req),     32'(m_req));
            chk("m_addr",  bus.mem_addr,         m_pc);
            chk("m_valid", 32'(bus.instr_valid), 32'(m_valid));
            chk("m_fault", 32'(bus.fault),       32'(m_fault));
            if (m_valid) begin
                chk("m_instr",  bus.instr,            m_instr);
                chk("m_iaddr",  bus.addr_instruction, m_addr);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] data);
        bus.mem_ack = 1'b1; bus.mem_rdata = data;
        cyc();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic accept();
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
    endtask

    task automatic load(input logic [31:0] pc);
        bus.pc_load = 1'b1; bus.pc_next = pc;
        cyc();
        bus.pc_load = 1'b0; bus.pc_next = '0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no completion expected finish by 50000");
        $fatal(1, "watchdog");
    end

    int n_req;

    initial begin
        rst = 1'b1;
        bus.pc_next = '0; bus.pc_load = 1'b0; bus.mem_ack = 1'b0;
        bus.mem_rdata = '0; bus.instr_ready = 1'b0;
        cyc(); cyc();
        chk("rst_req",   32'(bus.mem_req),     32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_fault", 32'(bus.fault),       32'd0);
        chk("rst_instr", bus.instr,            32'd0);
        chk("rst_pc",    bus.mem_addr,         32'd0);

        rst = 1'b0;
        cyc();
        chk("first_req",  32'(bus.mem_req), 32'd1);
        chk("first_addr", bus.mem_addr,     32'd0);
        fetch(32'h0050_0093);
        chk("ack_instr", bus.instr,            32'h0050_0093);
        chk("ack_valid", 32'(bus.instr_valid), 32'd1);
        chk("ack_iaddr", bus.addr_instruction, 32'd0);
        chk("ack_noreq", 32'(bus.mem_req),     32'd0);

        // pc_load while holding is ignored; instruction stays put
        load(32'h200);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("hold_instr", bus.instr,            32'h0050_0093);
            chk("hold_valid", 32'(bus.instr_valid), 32'd1);
        end
        accept();
        chk("hs_valid", 32'(bus.instr_valid), 32'd0);
        chk("hs_noreq", 32'(bus.mem_req),     32'd0);
        load(32'h4);
        chk("pc4_req",  32'(bus.mem_req), 32'd1);
        chk("pc4_addr", bus.mem_addr,     32'h4);

        // pc_load during FETCH is ignored
        load(32'h100);
        chk("ign_addr", bus.mem_addr,     32'h4);
        chk("ign_req",  32'(bus.mem_req), 32'd1);
        repeat (3) cyc();
        fetch(32'h1111_1111);
        chk("f4_iaddr", bus.addr_instruction, 32'h4);
        accept();
        load(32'h100);
        chk("pc100_addr", bus.mem_addr, 32'h100);

        fetch(32'h2222_2222);
        accept();
        load(32'hFFFF_FFFC);
        chk("top_addr", bus.mem_addr, 32'hFFFF_FFFC);
        fetch(32'h3333_3333);
        chk("top_iaddr", bus.addr_instruction, 32'hFFFF_FFFC);
        accept();

        // Misaligned target traps and stays trapped
        load(32'h102);
        chk("mis_fault", 32'(bus.fault),   32'd1);
        chk("mis_req",   32'(bus.mem_req), 32'd0);
        chk("mis_pc",    bus.mem_addr,     32'hFFFF_FFFC);
        bus.mem_ack = 1'b1; bus.pc_load = 1'b1; bus.pc_next = 32'h8; bus.instr_ready = 1'b1;
        repeat (4) cyc();
        bus.mem_ack = 1'b0; bus.pc_load = 1'b0; bus.pc_next = '0; bus.instr_ready = 1'b0;
        chk("mis_hold_fault", 32'(bus.fault),       32'd1);
        chk("mis_hold_req",   32'(bus.mem_req),     32'd0);
        chk("mis_hold_valid", 32'(bus.instr_valid), 32'd0);

        // Timeout: request held for exactly TMO cycles
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("tmo_rst_fault", 32'(bus.fault), 32'd0);
        n_req = 0;
        for (int i = 0; i < 40 && bus.fault == FAULT_NONE; i++) begin
            cyc();
            if (bus.mem_req) n_req++;
        end
        chk("tmo_cycles", 32'(n_req),      32'd16);
        chk("tmo_fault",  32'(bus.fault),  32'd2);
        chk("tmo_req",    32'(bus.mem_req), 32'd0);
        cyc();
        chk("tmo_hold", 32'(bus.fault), 32'd2);

        // Reset mid-wait with a coinciding ack
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        fetch(32'h4444_4444);
        accept();
        load(32'h40);
        chk("pc40_addr", bus.mem_addr, 32'h40);
        repeat (2) cyc();
        rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        cyc();
        rst = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        chk("rr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rr_pc",    bus.mem_addr,         RST_PC);
        chk("rr_instr", bus.instr,            32'd0);
        chk("rr_req",   32'(bus.mem_req),     32'd0);
        cyc();
        chk("rr_refetch_req",  32'(bus.mem_req), 32'd1);
        chk("rr_refetch_addr", bus.mem_addr,     RST_PC);
        fetch(32'h5555_5555);
        chk("rr_instr2", bus.instr,            32'h5555_5555);
        chk("rr_iaddr2", bus.addr_instruction, RST_PC);
        accept();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
